// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam int UART_FIFO_DEPTH = 16;

    localparam logic [15:0] UART_DATA_ADDR = 16'h0001;
    localparam logic [15:0] UART_STAT_ADDR = 16'h0002;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry byte queue with wrap-bit pointers and a zero-gated head read
module byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clki,
    input  logic          rst_in,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // pointers advance independently; the extra top bit tells full from empty
    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage is not reset; a push while full lands on the slot being popped
    always_ff @(posedge clki) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains the UART holding register into a FIFO read by the CPU bus decoder
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clki,
    input  logic          rst_in,
    input  logic [7:0]    rx_data,
    input  logic          rx_new,
    output logic          uart_read,
    input  logic          bus_pop,
    input  logic          bus_clr,
    output logic [7:0]    rd_data,
    output logic          avail,
    output logic          overrun,
    output logic [AW:0]   level
);

    state_t state;
    state_t state_nx;
    logic   bus_pop_q;
    logic   bus_clr_q;
    logic   pop;
    logic   push;
    logic   drop;
    logic   full;
    logic   empty;

    assign avail = ~empty;
    assign pop   = bus_pop & ~bus_pop_q & avail;

    // capture state register
    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    // one capture per rx_new high period: ack, then wait for the UART to drop it
    always_comb begin
        state_nx = state == IDLE     ? (rx_new ? ACK : IDLE) :
                   state == ACK      ? WAIT_LOW :
                   state == WAIT_LOW ? (rx_new ? WAIT_LOW : IDLE) : IDLE;
    end

    // a pop in the same cycle frees a slot, so a full FIFO still accepts the byte
    always_comb begin
        uart_read = state == ACK;
        push      = state == IDLE && rx_new && (!full || pop);
        drop      = state == IDLE && rx_new && full && !pop;
    end

    // bus strobe edge detectors and sticky overrun; a drop outranks a clear
    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            bus_pop_q <= 1'b0;
            bus_clr_q <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            bus_pop_q <= bus_pop;
            bus_clr_q <= bus_clr;
            if (drop)                       overrun <= 1'b1;
            else if (bus_clr && !bus_clr_q) overrun <= 1'b0;
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clki  (clki),
        .rst_in(rst_in),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-based reference model, directed scenarios and randomized traffic
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_new = 1'b0;
    logic       bus_pop = 1'b0;
    logic       bus_clr = 1'b0;
    logic       uart_read;
    logic [7:0] rd_data;
    logic       avail;
    logic       overrun;
    logic [4:0] level;

    int total = 0;
    int bad = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clki     (clk),
        .rst_in   (rst_n),
        .rx_data  (rx_data),
        .rx_new   (rx_new),
        .uart_read(uart_read),
        .bus_pop  (bus_pop),
        .bus_clr  (bus_clr),
        .rd_data  (rd_data),
        .avail    (avail),
        .overrun  (overrun),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: bytes stored in a queue, capture windows tracked per rx_new pulse
    logic [7:0] q[$];
    bit m_ovr, m_ack, m_skip, m_wait, m_pop_q, m_clr_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovr = 0; m_ack = 0; m_skip = 0; m_wait = 0; m_pop_q = 0; m_clr_q = 0;
        end else begin
            bit p, c, cap;
            p = bus_pop && !m_pop_q && q.size() != 0;
            c = bus_clr && !m_clr_q;
            cap = rx_new && !m_skip && !m_wait;
            m_pop_q = bus_pop;
            m_clr_q = bus_clr;
            if (p) void'(q.pop_front());
            if (c) m_ovr = 0;
            if (cap) begin
                if (q.size() < DEPTH) q.push_back(rx_data);
                else m_ovr = 1;
            end
            m_ack = cap;
            if (cap) begin m_skip = 1; m_wait = 1; end
            else if (m_skip) m_skip = 0;
            else if (m_wait && !rx_new) m_wait = 0;
        end
    end

    // every cycle out of reset, outputs must follow the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 32'(level), 32'(q.size()));
            check("avail", 32'(avail), 32'(q.size() != 0));
            check("rd_data", 32'(rd_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("uart_read", 32'(uart_read), 32'(m_ack));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit with_pop);
        int n = 0;
        rx_data = b;
        rx_new = 1'b1;
        if (with_pop) bus_pop = 1'b1;
        do begin @(negedge clk); n++; end while (!uart_read && n < 10);
        if (!uart_read) check("ack_timeout", 32'(uart_read), 32'h1);
        bus_pop = 1'b0;
        rx_new = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_once();
        bus_pop = 1'b1;
        @(negedge clk);
        bus_pop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses, hold, idle_cnt;
        bit acked;
        logic [7:0] b;
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level), 32'h0);
        check("rst_avail", 32'(avail), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_read", 32'(uart_read), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        send_byte(8'hA5, 0);
        check("single_level", 32'(level), 32'h1);
        check("single_data", 32'(rd_data), 32'hA5);
        pop_once();
        check("single_empty", 32'(avail), 32'h0);
        check("single_zero", 32'(rd_data), 32'h0);

        rx_data = 8'h3C;
        rx_new = 1'b1;
        pulses = 0;
        repeat (10) begin @(negedge clk); pulses += int'(uart_read); end
        rx_new = 1'b0;
        repeat (2) @(negedge clk);
        check("stuck_pulses", 32'(pulses), 32'h1);
        check("stuck_level", 32'(level), 32'h1);
        pop_once();

        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0);
        send_byte(8'hFF, 0);
        check("full_level", 32'(level), 32'd16);
        check("full_overrun", 32'(overrun), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_order", 32'(rd_data), 32'(i));
            pop_once();
        end
        check("drained", 32'(level), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        bus_clr = 1'b1;
        @(negedge clk);
        bus_clr = 1'b0;
        @(negedge clk);
        check("ovr_clr", 32'(overrun), 32'h0);

        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 0);
        send_byte(8'hFF, 1);
        check("coinc_level", 32'(level), 32'd16);
        check("coinc_overrun", 32'(overrun), 32'h0);
        for (int i = 1; i < DEPTH; i++) begin
            check("coinc_order", 32'(rd_data), 32'(8'h10 + i));
            pop_once();
        end
        check("coinc_last", 32'(rd_data), 32'hFF);
        pop_once();

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            send_byte(b, 0);
            check("wrap_level", 32'(level), 32'h1);
            check("wrap_data", 32'(rd_data), 32'(b));
            pop_once();
        end

        for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 0);
        rx_data = 8'h77;
        rx_new = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_level", 32'(level), 32'h5);
        check("pre_rst_state", 32'(dut.state), 32'(WAIT_LOW));
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_avail", 32'(avail), 32'h0);
        check("mid_rst_data", 32'(rd_data), 32'h0);
        check("mid_rst_read", 32'(uart_read), 32'h0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("recap_level", 32'(level), 32'h1);
        check("recap_data", 32'(rd_data), 32'h77);
        @(negedge clk);
        rx_new = 1'b0;
        repeat (2) @(negedge clk);
        pop_once();

        hold = 0;
        idle_cnt = 2;
        acked = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_new) begin
                if (uart_read) acked = 1;
                if (acked) begin
                    if (hold == 0) begin rx_new = 1'b0; acked = 0; idle_cnt = 0; end
                    else hold--;
                end
            end else begin
                idle_cnt++;
                if (idle_cnt >= 2 && $urandom_range(0, 2) == 0) begin
                    rx_new = 1'b1;
                    rx_data = 8'($urandom);
                    hold = $urandom_range(0, 6);
                end
            end
            bus_pop = (i < 1500) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 0);
            bus_clr = $urandom_range(0, 19) == 0;
        end
        rx_new = 1'b0;
        bus_pop = 1'b0;
        bus_clr = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
